// File: rtl/rmc_pkg.sv
// -----------------------------------------------------------------------------
// rmc_pkg
// Shared types and defaults for the RMC enable front-end.
//
// Contents:
//   rmc_state_e        - debounce FSM state encoding (all four codes are used)
//   RMC_RISE_TICKS_DEF - default number of ticks to qualify a 0->1 change
//   RMC_FALL_TICKS_DEF - default number of ticks to qualify a 1->0 change
//   RMC_GLITCH_MAX     - saturation value of the glitch counter
//   rmcStableState()   - maps a settled level onto its stable FSM state
// -----------------------------------------------------------------------------
package rmc_pkg;

   typedef enum logic [1:0] {
      ST_HI  = 2'b00,   // settled high
      ST_QLO = 2'b01,   // high, qualifying a drop
      ST_LO  = 2'b10,   // settled low
      ST_QHI = 2'b11    // low, qualifying a rise
   } rmc_state_e;

   localparam int          RMC_RISE_TICKS_DEF = 20;
   localparam int          RMC_FALL_TICKS_DEF = 5;
   localparam logic [7:0]  RMC_GLITCH_MAX     = 8'hFF;

   function automatic rmc_state_e rmcStableState(input logic level);
      return level ? ST_HI : ST_LO;
   endfunction

endpackage

// File: rtl/rmc_sync_ff.sv
// -----------------------------------------------------------------------------
// rmc_sync_ff
// Generic N-stage flop synchroniser for asynchronous board inputs.
//
// Parameters:
//   STAGES  - number of flops in the chain (2 or more)
//   WIDTH   - number of independent single-bit inputs
//   RST_VAL - level every flop takes on reset
//
// Ports:
//   clk_in  - destination clock
//   iRst_n  - asynchronous, active-low reset
//   iAsync  - raw asynchronous input(s)
//   oSync   - last stage of the chain, safe to use in clk_in logic
// -----------------------------------------------------------------------------
module rmc_sync_ff #(
   parameter int   STAGES  = 2,
   parameter int   WIDTH   = 1,
   parameter logic RST_VAL = 1'b1
) (
   input  logic             clk_in,
   input  logic             iRst_n,
   input  logic [WIDTH-1:0] iAsync,
   output logic [WIDTH-1:0] oSync
);

   logic [STAGES-1:0][WIDTH-1:0] syncChain;

   always_ff @(posedge clk_in or negedge iRst_n) begin
      if (!iRst_n) begin
         syncChain <= {STAGES{{WIDTH{RST_VAL}}}};
      end else begin
         // Element 0 is the metastability-catching flop; the top element is
         // the only one other logic may look at.
         syncChain <= {syncChain[STAGES-2:0], iAsync};
      end
   end

   assign oSync = syncChain[STAGES-1];

endmodule

// File: rtl/rmc_enable_debounce.sv
// -----------------------------------------------------------------------------
// rmc_enable_debounce
// Qualifies the raw RMC enable pin: synchronises it into clk_in, then requires
// the new level to persist for a number of iTick strobes (separately for the
// rising and falling direction) before the debounced output follows.
//
// Optional build macro: RMC_ENABLE_GLITCH_CNT_EN
//   defined   - oGlitch_cnt counts aborted qualifications, saturating at 8'hFF
//   undefined - oGlitch_cnt is tied to 8'h00 (FSM behaviour is identical)
//
// Ports:
//   clk_in               - system clock
//   iRst_n               - asynchronous, active-low reset
//   iTick                - one-cycle timebase strobe, synchronous to clk_in
//   iClear               - synchronous clear; snaps state/output to wSync
//   iRMC_enable_raw      - asynchronous raw enable pin
//   oRMC_enable_debounce - qualified enable level (registered)
//   oRise_pulse          - one-cycle pulse on an output 0->1 transition
//   oFall_pulse          - one-cycle pulse on an output 1->0 transition
//   oGlitch_cnt          - saturating count of aborted qualifications
//   oState_dbg           - current FSM state (rmc_state_e encoding)
// -----------------------------------------------------------------------------
module rmc_enable_debounce
   import rmc_pkg::*;
#(
   parameter int               SYNC_STAGES = 2,     // legal 2..4
   parameter int               CNT_W       = 16,
   parameter logic [CNT_W-1:0] RISE_TICKS  = CNT_W'(RMC_RISE_TICKS_DEF),
   parameter logic [CNT_W-1:0] FALL_TICKS  = CNT_W'(RMC_FALL_TICKS_DEF),
   parameter logic             RST_VAL     = 1'b1
) (
   input  logic       clk_in,
   input  logic       iRst_n,
   input  logic       iTick,
   input  logic       iClear,
   input  logic       iRMC_enable_raw,
   output logic       oRMC_enable_debounce,
   output logic       oRise_pulse,
   output logic       oFall_pulse,
   output logic [7:0] oGlitch_cnt,
   output logic [1:0] oState_dbg
);

   localparam rmc_state_e RST_STATE = RST_VAL ? ST_HI : ST_LO;

   // Counter value at which the final qualifying tick completes a transition.
   // Only consulted when the matching *_TICKS parameter is non-zero.
   localparam logic [CNT_W-1:0] RISE_LAST = RISE_TICKS - CNT_W'(1);
   localparam logic [CNT_W-1:0] FALL_LAST = FALL_TICKS - CNT_W'(1);

   logic             wSync;
   rmc_state_e       state;
   rmc_state_e       stateNext;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cntNext;
   logic             outNext;
   logic             riseNext;
   logic             fallNext;

   // --------------------------------------------------------------------------
   // Pin synchroniser
   // --------------------------------------------------------------------------
   rmc_sync_ff #(
      .STAGES  (SYNC_STAGES),
      .WIDTH   (1),
      .RST_VAL (RST_VAL)
   ) uSync (
      .clk_in (clk_in),
      .iRst_n (iRst_n),
      .iAsync (iRMC_enable_raw),
      .oSync  (wSync)
   );

   // --------------------------------------------------------------------------
   // Debounce FSM next-state logic
   // In a qualifying state, a return of wSync to the settled level is checked
   // before the tick, so an abort coinciding with the final tick wins.
   // --------------------------------------------------------------------------
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      outNext   = oRMC_enable_debounce;
      riseNext  = 1'b0;
      fallNext  = 1'b0;

      if (iClear) begin
         stateNext = rmcStableState(wSync);
         cntNext   = '0;
         outNext   = wSync;
      end else begin
         case (state)
            ST_HI: begin
               if (!wSync) begin
                  if (FALL_TICKS == '0) begin
                     stateNext = ST_LO;
                     outNext   = 1'b0;
                     fallNext  = 1'b1;
                  end else begin
                     stateNext = ST_QLO;
                     cntNext   = '0;
                  end
               end
            end

            ST_QLO: begin
               if (wSync) begin
                  stateNext = ST_HI;
                  cntNext   = '0;
               end else if (iTick) begin
                  if (cnt == FALL_LAST) begin
                     stateNext = ST_LO;
                     cntNext   = '0;
                     outNext   = 1'b0;
                     fallNext  = 1'b1;
                  end else begin
                     cntNext = cnt + CNT_W'(1);
                  end
               end
            end

            ST_LO: begin
               if (wSync) begin
                  if (RISE_TICKS == '0) begin
                     stateNext = ST_HI;
                     outNext   = 1'b1;
                     riseNext  = 1'b1;
                  end else begin
                     stateNext = ST_QHI;
                     cntNext   = '0;
                  end
               end
            end

            ST_QHI: begin
               if (!wSync) begin
                  stateNext = ST_LO;
                  cntNext   = '0;
               end else if (iTick) begin
                  if (cnt == RISE_LAST) begin
                     stateNext = ST_HI;
                     cntNext   = '0;
                     outNext   = 1'b1;
                     riseNext  = 1'b1;
                  end else begin
                     cntNext = cnt + CNT_W'(1);
                  end
               end
            end

            default: begin
               // Unreachable with a 2-bit encoding, kept so a corrupted state
               // register lands somewhere well defined.
               stateNext = RST_STATE;
               cntNext   = '0;
               outNext   = RST_VAL;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // State, counter and registered outputs
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_in or negedge iRst_n) begin
      if (!iRst_n) begin
         state                <= RST_STATE;
         cnt                  <= '0;
         oRMC_enable_debounce <= RST_VAL;
         oRise_pulse          <= 1'b0;
         oFall_pulse          <= 1'b0;
      end else begin
         state                <= stateNext;
         cnt                  <= cntNext;
         oRMC_enable_debounce <= outNext;
         oRise_pulse          <= riseNext;
         oFall_pulse          <= fallNext;
      end
   end

   assign oState_dbg = state;

   // --------------------------------------------------------------------------
   // Glitch counter
   // --------------------------------------------------------------------------
`ifdef RMC_ENABLE_GLITCH_CNT_EN
   logic       abortEvt;
   logic [7:0] glitchCnt;

   // A qualification is aborted when wSync goes back to the settled level
   // while a qualifying state is active; iClear overrides the abort.
   assign abortEvt = !iClear &&
                     (((state == ST_QLO) &&  wSync) ||
                      ((state == ST_QHI) && !wSync));

   always_ff @(posedge clk_in or negedge iRst_n) begin
      if (!iRst_n) begin
         glitchCnt <= 8'h00;
      end else if (iClear) begin
         glitchCnt <= 8'h00;
      end else if (abortEvt && (glitchCnt != RMC_GLITCH_MAX)) begin
         glitchCnt <= glitchCnt + 8'd1;
      end
   end

   assign oGlitch_cnt = glitchCnt;
`else
   assign oGlitch_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_rmc_enable_debounce.sv
// -----------------------------------------------------------------------------
// tb_rmc_enable_debounce
// Bench for rmc_enable_debounce. Two instances share the stimulus:
//   dut 0 - default parameters (RISE 20, FALL 5, 2 sync stages)
//   dut 1 - FALL_TICKS 0 (immediate drop), RISE_TICKS 2
// The reference model describes behaviour as "how long has the synchronised
// pin disagreed with the output, and how many ticks has that run seen", with
// the synchroniser modelled as a delay queue of raw samples.
// -----------------------------------------------------------------------------
module tb_rmc_enable_debounce;
   import rmc_pkg::*;

   localparam int SYNC_STAGES = 2;
   localparam int NDUT        = 2;
`ifdef RMC_ENABLE_GLITCH_CNT_EN
   localparam bit GLITCH_EN = 1'b1;
`else
   localparam bit GLITCH_EN = 1'b0;
`endif

   // ---------------------------------------------------------------- clock/reset
   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic       iRst_n;
   logic       iTick;
   logic       iClear;
   logic       raw;

   logic       out_0, rise_0, fall_0;
   logic [7:0] glitch_0;
   logic [1:0] state_0;
   logic       out_1, rise_1, fall_1;
   logic [7:0] glitch_1;
   logic [1:0] state_1;

   rmc_enable_debounce u_dut0 (
      .clk_in               (clk_in),
      .iRst_n               (iRst_n),
      .iTick                (iTick),
      .iClear               (iClear),
      .iRMC_enable_raw      (raw),
      .oRMC_enable_debounce (out_0),
      .oRise_pulse          (rise_0),
      .oFall_pulse          (fall_0),
      .oGlitch_cnt          (glitch_0),
      .oState_dbg           (state_0)
   );

   rmc_enable_debounce #(
      .RISE_TICKS (16'd2),
      .FALL_TICKS (16'd0)
   ) u_dut1 (
      .clk_in               (clk_in),
      .iRst_n               (iRst_n),
      .iTick                (iTick),
      .iClear               (iClear),
      .iRMC_enable_raw      (raw),
      .oRMC_enable_debounce (out_1),
      .oRise_pulse          (rise_1),
      .oFall_pulse          (fall_1),
      .oGlitch_cnt          (glitch_1),
      .oState_dbg           (state_1)
   );

   // ---------------------------------------------------------------- scoreboard
   int n_checks = 0;
   int n_errors = 0;
   logic [10:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- reference model
   bit sync_q[$];
   bit m_out[NDUT];
   bit m_run[NDUT];
   int m_ticks[NDUT];
   int m_glitch[NDUT];
   bit m_rise[NDUT];
   bit m_fall[NDUT];

   function automatic int rise_n(input int i);
      return (i == 0) ? 20 : 2;
   endfunction

   function automatic int fall_n(input int i);
      return (i == 0) ? 5 : 0;
   endfunction

   function automatic void push_exp();
      for (int i = 0; i < NDUT; i++)
         exp_q.push_back({m_out[i], m_rise[i], m_fall[i],
                          GLITCH_EN ? 8'(m_glitch[i]) : 8'h00});
   endfunction

   function automatic void model_reset();
      sync_q.delete();
      for (int s = 0; s < SYNC_STAGES; s++) sync_q.push_back(1'b1);
      for (int i = 0; i < NDUT; i++) begin
         m_out[i]    = 1'b1;
         m_run[i]    = 1'b0;
         m_ticks[i]  = 0;
         m_glitch[i] = 0;
         m_rise[i]   = 1'b0;
         m_fall[i]   = 1'b0;
      end
   endfunction

   function automatic void model_edge(input bit r, input bit tick, input bit clr);
      bit ws;
      int need;
      ws = sync_q.pop_front();
      sync_q.push_back(r);
      for (int i = 0; i < NDUT; i++) begin
         m_rise[i] = 1'b0;
         m_fall[i] = 1'b0;
         if (clr) begin
            m_out[i]    = ws;
            m_run[i]    = 1'b0;
            m_ticks[i]  = 0;
            m_glitch[i] = 0;
         end else if (ws != m_out[i]) begin
            need = m_out[i] ? fall_n(i) : rise_n(i);
            if (need == 0) begin
               m_rise[i] = !m_out[i];
               m_fall[i] = m_out[i];
               m_out[i]  = !m_out[i];
            end else if (!m_run[i]) begin
               // First cycle of disagreement opens the run; ticks count after.
               m_run[i]   = 1'b1;
               m_ticks[i] = 0;
            end else if (tick) begin
               m_ticks[i]++;
               if (m_ticks[i] == need) begin
                  m_rise[i] = !m_out[i];
                  m_fall[i] = m_out[i];
                  m_out[i]  = !m_out[i];
                  m_run[i]  = 1'b0;
               end
            end
         end else if (m_run[i]) begin
            m_run[i] = 1'b0;
            if (m_glitch[i] < 255) m_glitch[i]++;
         end
      end
   endfunction

   function automatic logic [10:0] act_word(input int i);
      if (i == 0) return {out_0, rise_0, fall_0, glitch_0};
      return {out_1, rise_1, fall_1, glitch_1};
   endfunction

   task automatic check_outputs();
      logic [10:0] e;
      logic [10:0] a;
      for (int i = 0; i < NDUT; i++) begin
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL exp_q_underflow: observed empty queue expected entry for dut%0d", i);
         end else begin
            e = exp_q.pop_front();
            a = act_word(i);
            chk($sformatf("dut%0d_out", i),    32'(a[10]),  32'(e[10]));
            chk($sformatf("dut%0d_rise", i),   32'(a[9]),   32'(e[9]));
            chk($sformatf("dut%0d_fall", i),   32'(a[8]),   32'(e[8]));
            chk($sformatf("dut%0d_glitch", i), 32'(a[7:0]), 32'(e[7:0]));
         end
      end
   endtask

   // ---------------------------------------------------------------- driver tasks
   task automatic step();
      @(posedge clk_in);
      if (!iRst_n) model_reset();
      else         model_edge(raw, iTick, iClear);
      push_exp();
      #1;
      check_outputs();
   endtask

   // n cycles with raw held at r and a tick every 'period' cycles (0 = none).
   task automatic run(input int n, input int period, input bit r);
      raw = r;
      for (int i = 0; i < n; i++) begin
         iTick = (period > 0) && ((i % period) == (period - 1));
         step();
      end
      iTick = 1'b0;
   endtask

   task automatic async_reset(input int hold_cycles);
      iRst_n = 1'b0;
      #2;
      model_reset();
      chk("rst_async_out0",    32'(out_0),    32'd1);
      chk("rst_async_out1",    32'(out_1),    32'd1);
      chk("rst_async_rise0",   32'(rise_0),   32'd0);
      chk("rst_async_fall0",   32'(fall_0),   32'd0);
      chk("rst_async_glitch0", 32'(glitch_0), 32'd0);
      repeat (hold_cycles) step();
      iRst_n = 1'b1;
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation time limit");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      int hold;
      iRst_n = 1'b0;
      iTick  = 1'b0;
      iClear = 1'b0;
      raw    = 1'b1;
      model_reset();
      repeat (3) step();
      chk("reset_out",   32'(out_0),   32'd1);
      chk("reset_state", 32'(state_0), 32'(ST_HI));
      chk("reset_rise",  32'(rise_0),  32'd0);
      iRst_n = 1'b1;
      run(5, 0, 1);

      // Falling qualification, ticks every 10 clocks.
      run(70, 10, 0);
      chk("fall_done", 32'(out_0), 32'd0);

      // Rising qualification needs 20 ticks.
      run(230, 10, 1);
      chk("rise_done", 32'(out_0), 32'd1);

      // Short lows: 3 ticks then back high, repeated past saturation.
      repeat (300) begin
         run(8, 2, 0);
         run(4, 0, 1);
      end
      chk("glitch_sat",     32'(glitch_0), GLITCH_EN ? 32'hFF : 32'h00);
      chk("glitch_sat_out", 32'(out_0),    32'd1);

      // Clear, then abort landing on the same cycle as the 5th tick.
      iClear = 1'b1;
      step();
      iClear = 1'b0;
      chk("clear_glitch", 32'(glitch_0), 32'd0);
      run(3, 0, 0);
      run(4, 1, 0);
      run(2, 0, 1);
      run(1, 1, 1);
      run(5, 0, 1);
      chk("abort_out",    32'(out_0),    32'd1);
      chk("abort_glitch", 32'(glitch_0), GLITCH_EN ? 32'd1 : 32'd0);

      // iClear during a rising qualification.
      run(70, 10, 0);
      chk("low_again", 32'(out_0), 32'd0);
      run(3, 0, 1);
      run(6, 2, 1);
      iClear = 1'b1;
      step();
      iClear = 1'b0;
      chk("clear_qhi_out",    32'(out_0),    32'd1);
      chk("clear_qhi_rise",   32'(rise_0),   32'd0);
      chk("clear_qhi_glitch", 32'(glitch_0), 32'd0);

      // Reset in the middle of a rising qualification.
      run(70, 10, 0);
      chk("low_before_rst", 32'(out_0), 32'd0);
      run(3, 0, 1);
      run(10, 2, 1);
      raw = 1'b0;
      async_reset(2);
      run(40, 10, 0);
      chk("post_rst_hold", 32'(out_0), 32'd1);
      run(20, 10, 0);
      chk("post_rst_fall", 32'(out_0), 32'd0);

      // Randomised segments.
      repeat (150) begin
         hold = $urandom_range(1, 40);
         raw  = 1'($urandom_range(0, 1));
         for (int i = 0; i < hold; i++) begin
            iTick  = ($urandom_range(0, 3) == 0);
            iClear = ($urandom_range(0, 199) == 0);
            step();
         end
         iTick  = 1'b0;
         iClear = 1'b0;
         if ($urandom_range(0, 49) == 0) async_reset(1);
      end

      run(10, 0, raw);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rmc_enable_debounce.md
Name: rmc_enable_debounce

Overview:
- Front-end qualifier for the raw RMC enable pin.
- Synchronises the pin into clk_in and applies independent tick-based assert and deassert filter times.
- Produces the debounced level consumed by the RMC enable delay/control logic, plus one-cycle edge pulses and a glitch count for status registers.
- Sits between the board-level RMC enable input and the RMC enable delay control.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on iRMC_enable_raw; legal values 2..4.
- CNT_W, 16, width of the filter counter.
- RISE_TICKS, 16'd20, number of iTick pulses the input must stay high before the output asserts; 0 means immediate.
- FALL_TICKS, 16'd5, number of iTick pulses the input must stay low before the output deasserts; 0 means immediate.
- RST_VAL, 1'b1, reset level of the synchroniser, the output and the initial state.

Ports:
- clk_in  input  1  system clock.
- iRst_n  input  1  asynchronous, active-low reset.
- iTick  input  1  one-clk_in-cycle timebase strobe, synchronous to clk_in.
- iClear  input  1  synchronous clear, active-high.
- iRMC_enable_raw  input  1  asynchronous raw RMC enable pin.
- oRMC_enable_debounce  output  1  qualified enable level.
- oRise_pulse  output  1  one-cycle pulse when the output goes 0->1.
- oFall_pulse  output  1  one-cycle pulse when the output goes 1->0.
- oGlitch_cnt  output  8  saturating count of aborted qualifications.

Behaviour:
- Reset (async) values:
  - Synchroniser flops = RST_VAL.
  - State = ST_HI if RST_VAL is 1, otherwise ST_LO.
  - Counter = 0.
  - oRMC_enable_debounce = RST_VAL.
  - oRise_pulse = 0, oFall_pulse = 0, oGlitch_cnt = 0.
- Synchroniser: wSync is the last stage of the SYNC_STAGES chain. All decisions below use wSync only.
- FSM states: ST_HI, ST_QLO, ST_LO, ST_QHI.
- ST_HI:
  - If wSync = 0 and FALL_TICKS = 0, go to ST_LO; output drops and oFall_pulse fires on the same edge.
  - If wSync = 0 and FALL_TICKS != 0, go to ST_QLO and clear the counter.
- ST_QLO:
  - If wSync = 1, return to ST_HI, clear the counter and increment oGlitch_cnt (saturating).
  - Otherwise, on iTick with counter = FALL_TICKS-1, go to ST_LO, drive the output to 0 and fire oFall_pulse.
  - Otherwise, on iTick, increment the counter.
  - With no iTick, hold the counter.
- ST_LO and ST_QHI mirror ST_HI and ST_QLO, using RISE_TICKS, the output going to 1 and oRise_pulse.
- Output timing:
  - The output is registered and changes on the same edge as the entry into ST_HI or ST_LO.
  - Latency from the wSync change is the qualifying iTick count plus 0 cycles of registered delay.
  - Add SYNC_STAGES cycles for the raw-to-wSync path.
- Pulses: exactly one clk_in cycle wide, never both in the same cycle, and never asserted by reset or iClear.
- Abort versus completion in the same cycle: if wSync returns to the stable level in the cycle where the final iTick arrives, the abort wins. No transition occurs and the glitch is counted.
- The counter compares in CNT_W bits and never wraps. The threshold is always reached before 2^CNT_W-1.
- iClear:
  - Forces state to ST_HI or ST_LO according to the current wSync.
  - Output = wSync, counter = 0, oGlitch_cnt = 0, no pulse.
  - iClear has priority over all FSM activity.
- Reset mid-qualification discards all progress and restores the reset values.
- Illegal state encoding recovers to the reset state on the next edge.

Optional Feature:
- Macro RMC_ENABLE_GLITCH_CNT_EN.
- Defined: the 8-bit saturating glitch counter is implemented as described; it saturates at 8'hFF, and abort events at 8'hFF leave it at 8'hFF.
- Undefined: no counter logic; oGlitch_cnt is tied to 8'h00. FSM abort behaviour is unchanged.

Decomposition:
- Package rmc_pkg:
  - Enum for the state encoding (ST_HI, ST_QLO, ST_LO, ST_QHI).
  - Default constants RMC_RISE_TICKS_DEF = 20, RMC_FALL_TICKS_DEF = 5, RMC_GLITCH_MAX = 8'hFF.
- One sub-module: rmc_sync_ff, a parameterised N-stage synchroniser with a reset value parameter, reusable for other board inputs.

Test Plan:
- Reset with RST_VAL = 1 and raw = 1 -> output = 1, no pulses; raw -> 0 held for 5 ticks -> output = 0 on the 5th tick edge, oFall_pulse high for exactly 1 cycle.
- Raw low at 0 -> raw goes high, ticks every 10 clocks -> output rises exactly on the 20th tick after wSync = 1, oRise_pulse = 1 cycle.
- In ST_HI, raw low for 3 ticks then high -> output stays 1 and oGlitch_cnt 0 -> 1; repeat 300 times -> oGlitch_cnt = 8'hFF (macro defined) or 8'h00 (undefined).
- In ST_QLO with counter = 4, wSync returns to 1 in the same cycle as the 5th tick -> no fall; glitch counted.
- FALL_TICKS = 0: raw goes low -> output = 0 at SYNC_STAGES+1 clocks with a fall pulse. Also, iClear asserted during ST_QHI with raw = 1 -> output = 1 next edge, no rise pulse, oGlitch_cnt = 0.
- iRst_n asserted mid-qualification -> output = RST_VAL immediately (async); after release, a fresh full qualification is required.
